// File: rtl/bcd2bin16_seq.sv
// bcd2bin16_seq: five-digit BCD to 16-bit binary converter, one digit per clock (Horner form).
// Define BCD_DIGIT_CHECK_EN to flag invalid digits (>9) through err; otherwise err is tied low.
module bcd2bin16_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [3:0]  bcd4,
   input  logic [3:0]  bcd3,
   input  logic [3:0]  bcd2,
   input  logic [3:0]  bcd1,
   input  logic [3:0]  bcd0,
   output logic [15:0] binary,
   output logic        busy,
   output logic        done,
   output logic        overflow,
   output logic        err
);

   typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [4:0][3:0] dig_q, dig_d;
   logic [16:0]     acc_q, acc_d, acc_nxt;
   logic [2:0]      idx_q, idx_d;
   logic            done_q, done_d;
   logic            ovf_q, ovf_d;
   logic [15:0]     bin_q, bin_d;
   logic [3:0]      cur_dig;

   // acc*10 + digit, clamped at the 17-bit ceiling so out-of-range digits cannot wrap
   function automatic logic [16:0] mac10(input logic [16:0] acc, input logic [3:0] dig);
      logic [20:0] wide;
      wide = ({4'd0, acc} * 21'd10) + {17'd0, dig};
      return (wide > 21'h1FFFF) ? 17'h1FFFF : wide[16:0];
   endfunction

   function automatic logic [15:0] sat16(input logic [16:0] v);
      return v[16] ? 16'hFFFF : v[15:0];
   endfunction

   always_comb begin
      case (idx_q)
         3'd4:    cur_dig = dig_q[4];
         3'd3:    cur_dig = dig_q[3];
         3'd2:    cur_dig = dig_q[2];
         3'd1:    cur_dig = dig_q[1];
         default: cur_dig = dig_q[0];
      endcase
   end

   assign acc_nxt = mac10(acc_q, cur_dig);

`ifdef BCD_DIGIT_CHECK_EN
   logic bad_q, bad_d;
   logic err_q, err_d;
   logic cur_bad;

   assign cur_bad = (cur_dig > 4'd9);
`endif

   always_comb begin
      state_d = state_q;
      dig_d   = dig_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      bin_d   = bin_q;
      ovf_d   = ovf_q;
`ifdef BCD_DIGIT_CHECK_EN
      bad_d   = bad_q;
      err_d   = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               dig_d   = {bcd4, bcd3, bcd2, bcd1, bcd0};
               acc_d   = '0;
               idx_d   = 3'd4;
               state_d = CONV;
`ifdef BCD_DIGIT_CHECK_EN
               bad_d   = 1'b0;
`endif
            end
         end
         CONV: begin
            acc_d = acc_nxt;
            idx_d = idx_q - 3'd1;
`ifdef BCD_DIGIT_CHECK_EN
            bad_d = bad_q | cur_bad;
`endif
            if (idx_q == 3'd0) begin
               idx_d   = 3'd0;
               state_d = IDLE;
               done_d  = 1'b1;
               bin_d   = sat16(acc_nxt);
               ovf_d   = acc_nxt[16];
`ifdef BCD_DIGIT_CHECK_EN
               err_d   = bad_q | cur_bad;
               if (bad_q | cur_bad) begin
                  bin_d = 16'h0000;
                  ovf_d = 1'b0;
               end
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         dig_q   <= '0;
         acc_q   <= '0;
         idx_q   <= '0;
         done_q  <= 1'b0;
         bin_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dig_q   <= dig_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         bin_q   <= bin_d;
         ovf_q   <= ovf_d;
      end
   end

`ifdef BCD_DIGIT_CHECK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bad_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         bad_q <= bad_d;
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign busy     = (state_q == CONV);
   assign done     = done_q;
   assign binary   = bin_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_bcd2bin16_seq.sv
// Directed-vector bench for bcd2bin16_seq: latency, saturation, held start, reset abort, digit checking.
module tb_bcd2bin16_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [3:0]  bcd4, bcd3, bcd2, bcd1, bcd0;
   logic [15:0] binary;
   logic        busy, done, overflow, err;

   int passed = 0;
   int total  = 0;
   logic [15:0] hold_bin;

   bcd2bin16_seq dut (
      .clk(clk), .rst(rst), .start(start),
      .bcd4(bcd4), .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0),
      .binary(binary), .busy(busy), .done(done), .overflow(overflow), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Called at a negedge: pulses start, scrambles digits/start mid-conversion, checks full timing.
   task automatic run(input string tag, input logic [19:0] d,
                      input logic [15:0] eb, input logic eo, input logic ee);
      {bcd4, bcd3, bcd2, bcd1, bcd0} = d;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("%s busy%0d", tag, i), busy, 1);
         check($sformatf("%s done%0d", tag, i), done, 0);
         check($sformatf("%s hold%0d", tag, i), binary, hold_bin);
         if (i == 1) {bcd4, bcd3, bcd2, bcd1, bcd0} = ~d;
         if (i == 2) start = 1'b1;
         if (i == 3) start = 1'b0;
         @(negedge clk);
      end
      check({tag, " busy_end"}, busy, 0);
      check({tag, " done"}, done, 1);
      check({tag, " binary"}, binary, eb);
      check({tag, " overflow"}, overflow, eo);
      check({tag, " err"}, err, ee);
      hold_bin = eb;
      @(negedge clk);
      check({tag, " done_drop"}, done, 0);
      check({tag, " idle"}, busy, 0);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      {bcd4, bcd3, bcd2, bcd1, bcd0} = '0;
      hold_bin = 16'h0000;
      #2;
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst binary", binary, 16'h0000);
      check("rst overflow", overflow, 0);
      check("rst err", err, 0);
      @(negedge clk);
      rst = 1'b0;

      run("d12345", 20'h12345, 16'h3039, 1'b0, 1'b0);
      run("d65535", 20'h65535, 16'hFFFF, 1'b0, 1'b0);
      run("d65536", 20'h65536, 16'hFFFF, 1'b1, 1'b0);
      run("d99999", 20'h99999, 16'hFFFF, 1'b1, 1'b0);
      run("d00000", 20'h00000, 16'h0000, 1'b0, 1'b0);
`ifdef BCD_DIGIT_CHECK_EN
      run("dFFFFF", 20'hFFFFF, 16'h0000, 1'b0, 1'b1);
      run("d00A00", 20'h00A00, 16'h0000, 1'b0, 1'b1);
`else
      run("dFFFFF", 20'hFFFFF, 16'hFFFF, 1'b1, 1'b0);
      run("d00A00", 20'h00A00, 16'h03E8, 1'b0, 1'b0);
`endif

      // start held high: conversions back to back every 6 cycles
      {bcd4, bcd3, bcd2, bcd1, bcd0} = 20'h00042;
      start = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (k == 1 || k == 7) {bcd4, bcd3, bcd2, bcd1, bcd0} = 20'h99999;
         if (k == 4 || k == 10) {bcd4, bcd3, bcd2, bcd1, bcd0} = 20'h00042;
         if (k == 11) start = 1'b0;
         check($sformatf("held done%0d", k), done, (k == 5 || k == 11));
         check($sformatf("held busy%0d", k), busy, !(k == 5 || k == 11));
         if (k >= 5) check($sformatf("held bin%0d", k), binary, 16'h002A);
      end
      @(negedge clk);
      check("held idle", busy, 0);
      check("held done_end", done, 0);
      check("held err", err, 0);

      // reset on the third busy cycle aborts the conversion
      {bcd4, bcd3, bcd2, bcd1, bcd0} = 20'h12345;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("abort busy1", busy, 1);
      @(negedge clk);
      @(negedge clk);
      check("abort busy3", busy, 1);
      rst = 1'b1;
      #1;
      check("abort busy", busy, 0);
      check("abort binary", binary, 16'h0000);
      check("abort done", done, 0);
      hold_bin = 16'h0000;
      @(negedge clk);
      check("abort done_late", done, 0);
      rst = 1'b0;
      run("d00007", 20'h00007, 16'h0007, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/bcd2bin16_seq.md
BCD2BIN16_SEQ -- requirements
Module: bcd2bin16_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 start  input  1  conversion request, sampled only in IDLE.
REQ-005 bcd4..bcd0  input  4 each  BCD digits; bcd4 is the ten-thousands digit, bcd0 is the units digit.
REQ-006 binary  output  16  converted value, held until the next completed conversion.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  one-cycle pulse marking a completed conversion.
REQ-009 overflow  output  1  the last completed conversion had a decimal value above 65535.
REQ-010 err  output  1  the last completed conversion had an invalid digit; present in every build.

Function
REQ-011 FSM states SHALL be IDLE and CONV only.
REQ-012 IDLE with start=1 at an edge: capture all five digits, clear the 17-bit accumulator, set digit index to 4, enter CONV, assert busy.
REQ-013 Each CONV edge: acc = acc*10 + digit[index] (17-bit, bcd4 first); decrement index.
REQ-014 Edge processing index 0:
- enter IDLE, deassert busy;
- assert done for exactly one cycle;
- update binary, overflow and err.
REQ-015 Timing: start sampled at edge E0; busy high E0..E5; done high E5..E6; earliest next accepted start at E6, giving a 6-cycle throughput.
REQ-016 start while in CONV SHALL be ignored; captured digits SHALL NOT change mid-conversion.
REQ-017 Final acc > 65535: binary = 16'hFFFF, overflow=1; otherwise binary = acc[15:0], overflow=0.
REQ-018 Accumulator SHALL NOT wrap for any digit inputs 0..15: 17 bits, saturating at 17'h1FFFF.
REQ-019 binary, overflow and err SHALL change only in the done cycle.
REQ-020 done SHALL never be high while busy is high.

Reset
REQ-021 rst=1 SHALL immediately force:
- state IDLE, busy=0, done=0;
- binary=16'h0000, overflow=0, err=0;
- accumulator and index cleared.
REQ-022 Reset mid-conversion SHALL abort without a done pulse; a start sampled at the first edge after rst falls SHALL be accepted.

Configuration
REQ-023 Macro BCD_DIGIT_CHECK_EN defined:
- any captured digit > 9 sets an internal sticky flag during CONV;
- at completion: err=1, binary=16'h0000, overflow=0.
REQ-024 Macro BCD_DIGIT_CHECK_EN undefined:
- digits > 9 are accumulated arithmetically per REQ-013/REQ-017;
- err is tied to 0.

Verification
REQ-025 Digits 1,2,3,4,5 with a start pulse -> busy for 5 cycles, then done pulse, binary=16'h3039, overflow=0, err=0.
REQ-026 Digits 6,5,5,3,5 -> binary=16'hFFFF, overflow=0; digits 6,5,5,3,6 -> binary=16'hFFFF, overflow=1; digits 9,9,9,9,9 -> 16'hFFFF, overflow=1.
REQ-027 start held high continuously with digits 0,0,0,4,2 -> binary=16'h002A; done pulses every 6 cycles; digit changes during busy have no effect.
REQ-028 rst asserted on the 3rd busy cycle -> busy=0 and binary=0 immediately; no done pulse; a new conversion of 0,0,0,0,7 -> binary=16'h0007.
REQ-029 Digit bcd2=4'hA, others 0:
- with BCD_DIGIT_CHECK_EN: err=1, binary=16'h0000;
- without it: err=0, binary=16'h03E8.
